// File: rtl/sklansky_pipe_adder.sv
`default_nettype none
//==============================================================================
// Module   : sklansky_pipe_adder
// Brief    : Pipelined Sklansky prefix adder (a + b + cin) with valid/ready
//            flow control; `SKLANSKY_PIPE_SUB_EN adds a subtract control port.
// Revision : 1.0
//==============================================================================
module sklansky_pipe_adder #(
    parameter int WIDTH      = 32,
    parameter int PIPE_EVERY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SKLANSKY_PIPE_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int LEVELS = $clog2(WIDTH);

    logic                       w_en;
    logic [WIDTH-1:0]           w_b;
    logic                       w_cin;
    logic                       r_p_vld;
    logic [WIDTH-1:0]           r_p_g;
    logic [WIDTH-1:0]           r_p_p;
    logic                       r_p_cin;
    logic [LEVELS:0][WIDTH-1:0] w_lg;
    logic [LEVELS:0][WIDTH-1:0] w_lp;
    logic [LEVELS:0][WIDTH:0]   w_lr;
    logic [LEVELS:0]            w_lv;
    logic [WIDTH-1:0]           w_carry;
    logic [WIDTH-1:0]           w_sum;
    logic                       r_out_vld;
    logic [WIDTH-1:0]           r_sum;
    logic                       r_cout;
    logic                       r_ovf;

    assign w_en     = !r_out_vld || out_ready;
    assign in_ready = w_en;

`ifdef SKLANSKY_PIPE_SUB_EN
    assign w_b   = sub ? ~b : b;
    assign w_cin = cin | sub;
`else
    assign w_b   = b;
    assign w_cin = cin;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p_vld <= 1'b0;
        end else if (w_en) begin
            r_p_vld <= in_valid;
            r_p_g   <= a & w_b;
            r_p_p   <= a ^ w_b;
            r_p_cin <= w_cin;
        end
    end

    // Carry-in folded into bit 0 so the tree needs only clog2(WIDTH) levels;
    // w_lr keeps {raw p, cin} for the final sum XOR.
    assign w_lg[0] = {r_p_g[WIDTH-1:1], r_p_g[0] | (r_p_p[0] & r_p_cin)};
    assign w_lp[0] = r_p_p;
    assign w_lr[0] = {r_p_p, r_p_cin};
    assign w_lv[0] = r_p_vld;

    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        logic [WIDTH-1:0] w_cg;
        logic [WIDTH-1:0] w_cp;

        for (genvar k = 0; k < WIDTH; k++) begin : g_bit
            if (((k >> (l - 1)) & 1) == 0) begin : g_pass
                assign w_cg[k] = w_lg[l-1][k];
                assign w_cp[k] = w_lp[l-1][k];
            end else if ((((k >> (l - 1)) << (l - 1)) - 1) < (1 << (l - 1))) begin : g_gray
                localparam int J = ((k >> (l - 1)) << (l - 1)) - 1;
                assign w_cg[k] = w_lg[l-1][k] | (w_lp[l-1][k] & w_lg[l-1][J]);
                assign w_cp[k] = w_lp[l-1][k];
            end else begin : g_black
                localparam int J = ((k >> (l - 1)) << (l - 1)) - 1;
                assign w_cg[k] = w_lg[l-1][k] | (w_lp[l-1][k] & w_lg[l-1][J]);
                assign w_cp[k] = w_lp[l-1][k] & w_lp[l-1][J];
            end
        end

        if (((l % PIPE_EVERY) == 0) && (l != LEVELS)) begin : g_reg
            logic [WIDTH-1:0] r_g;
            logic [WIDTH-1:0] r_p;
            logic [WIDTH:0]   r_raw;
            logic             r_v;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v <= 1'b0;
                end else if (w_en) begin
                    r_v   <= w_lv[l-1];
                    r_g   <= w_cg;
                    r_p   <= w_cp;
                    r_raw <= w_lr[l-1];
                end
            end

            assign w_lg[l] = r_g;
            assign w_lp[l] = r_p;
            assign w_lr[l] = r_raw;
            assign w_lv[l] = r_v;
        end else begin : g_wire
            assign w_lg[l] = w_cg;
            assign w_lp[l] = w_cp;
            assign w_lr[l] = w_lr[l-1];
            assign w_lv[l] = w_lv[l-1];
        end
    end

    // Carry into bit k is the final group generate of bit k-1 (cin for bit 0).
    assign w_carry = {w_lg[LEVELS][WIDTH-2:0], w_lr[LEVELS][0]};
    assign w_sum   = w_lr[LEVELS][WIDTH:1] ^ w_carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vld <= 1'b0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_en) begin
            r_out_vld <= w_lv[LEVELS];
            if (w_lv[LEVELS]) begin
                r_sum  <= w_sum;
                r_cout <= w_lg[LEVELS][WIDTH-1];
                r_ovf  <= w_lg[LEVELS][WIDTH-1] ^ w_carry[WIDTH-1];
            end
        end
    end

    assign out_valid = r_out_vld;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sklansky_pipe_adder.sv
`default_nettype none
//==============================================================================
// Module   : tb_sklansky_pipe_adder
// Brief    : Directed and streaming bench for a 16-bit/PIPE_EVERY=2 and a
//            32-bit/PIPE_EVERY=1 instance of sklansky_pipe_adder.
// Revision : 1.0
//==============================================================================
module tb_sklansky_pipe_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v16_in, rdy16_in, cin16, vout16, rdy16_out, cout16, ovf16;
    logic [15:0] a16, b16, sum16;
    logic        v32_in, rdy32_in, cin32, vout32, rdy32_out, cout32, ovf32;
    logic [31:0] a32, b32, sum32;
`ifdef SKLANSKY_PIPE_SUB_EN
    logic        sub16;
`endif

    int n_pass  = 0;
    int n_total = 0;

    sklansky_pipe_adder #(.WIDTH(16), .PIPE_EVERY(2)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(v16_in), .in_ready(rdy16_in),
        .a(a16), .b(b16), .cin(cin16),
`ifdef SKLANSKY_PIPE_SUB_EN
        .sub(sub16),
`endif
        .out_valid(vout16), .out_ready(rdy16_out),
        .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    sklansky_pipe_adder #(.WIDTH(32), .PIPE_EVERY(1)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(v32_in), .in_ready(rdy32_in),
        .a(a32), .b(b32), .cin(cin32),
`ifdef SKLANSKY_PIPE_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(vout32), .out_ready(rdy32_out),
        .sum(sum32), .cout(cout32), .ovf(ovf32)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One beat through the 16-bit instance; lat counts edges from the
    // accepting edge (inclusive) to the edge where out_valid is seen high.
    task automatic send16(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                          output logic [15:0] s, output logic co, output logic ov,
                          output int lat);
        a16 = ia; b16 = ib; cin16 = ic; v16_in = 1'b1; rdy16_out = 1'b1;
        tick;
        v16_in = 1'b0;
        lat = 1;
        while (vout16 !== 1'b1 && lat < 20) begin
            tick;
            lat++;
        end
        s = sum16; co = cout16; ov = ovf16;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        v16_in = 1'b1; a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; rdy16_out = 1'b1;
        v32_in = 1'b1; a32 = 32'h1; b32 = 32'h2; cin32 = 1'b0; rdy32_out = 1'b1;
`ifdef SKLANSKY_PIPE_SUB_EN
        sub16 = 1'b0;
`endif
        tick;
        tick;
        n_total++; if (vout16 !== 1'b0) $display("FAIL reset_vout16 got %b want 0", vout16); else n_pass++;
        n_total++; if (sum16 !== 16'h0) $display("FAIL reset_sum16 got %h want 0000", sum16); else n_pass++;
        n_total++; if ({cout16, ovf16} !== 2'b00) $display("FAIL reset_cout_ovf16 got %b want 00", {cout16, ovf16}); else n_pass++;
        n_total++; if (vout32 !== 1'b0) $display("FAIL reset_vout32 got %b want 0", vout32); else n_pass++;
        n_total++; if ({sum32, cout32, ovf32} !== 34'h0) $display("FAIL reset_out32 got %h want 0", {sum32, cout32, ovf32}); else n_pass++;
        rst = 1'b0; v16_in = 1'b0; v32_in = 1'b0;
        #1;
        n_total++; if (rdy16_in !== 1'b1) $display("FAIL reset_in_ready16 got %b want 1", rdy16_in); else n_pass++;
        n_total++; if (rdy32_in !== 1'b1) $display("FAIL reset_in_ready32 got %b want 1", rdy32_in); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            tick;
            n_total++;
            if (vout16 !== 1'b0 || vout32 !== 1'b0)
                $display("FAIL reset_beat_dropped cycle %0d got vout16=%b vout32=%b want 0", i, vout16, vout32);
            else n_pass++;
        end
    endtask

    task automatic test_directed16;
        logic [15:0] ta [7] = '{16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h1234, 16'h7FFF, 16'h00FF};
        logic [15:0] tb [7] = '{16'h0001, 16'h0001, 16'hFFFF, 16'h8000, 16'h4321, 16'h0000, 16'h0F01};
        logic        tc [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] ts [7] = '{16'h0000, 16'h8000, 16'hFFFF, 16'h0000, 16'h5555, 16'h8000, 16'h1000};
        logic        tco[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        tov[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] s;
        logic        co, ov;
        int          lat;
        for (int i = 0; i < 7; i++) begin
            send16(ta[i], tb[i], tc[i], s, co, ov, lat);
            n_total++; if (lat !== 3) $display("FAIL dir16_latency vec %0d got %0d want 3", i, lat); else n_pass++;
            n_total++; if (s !== ts[i]) $display("FAIL dir16_sum vec %0d got %h want %h", i, s, ts[i]); else n_pass++;
            n_total++; if (co !== tco[i]) $display("FAIL dir16_cout vec %0d got %b want %b", i, co, tco[i]); else n_pass++;
            n_total++; if (ov !== tov[i]) $display("FAIL dir16_ovf vec %0d got %b want %b", i, ov, tov[i]); else n_pass++;
        end
    endtask

`ifdef SKLANSKY_PIPE_SUB_EN
    task automatic test_sub;
        logic [15:0] s;
        logic        co, ov;
        int          lat;
        sub16 = 1'b1;
        send16(16'd5, 16'd7, 1'b0, s, co, ov, lat);
        n_total++; if ({s, co} !== {16'hFFFE, 1'b0}) $display("FAIL sub_5_7 got %h/%b want fffe/0", s, co); else n_pass++;
        send16(16'd7, 16'd5, 1'b0, s, co, ov, lat);
        n_total++; if ({s, co} !== {16'h0002, 1'b1}) $display("FAIL sub_7_5 got %h/%b want 0002/1", s, co); else n_pass++;
        n_total++; if (lat !== 3) $display("FAIL sub_latency got %0d want 3", lat); else n_pass++;
        sub16 = 1'b0;
    endtask
`endif

    function automatic logic [33:0] model32(input logic [31:0] x, input logic [31:0] y, input logic c);
        logic [32:0] t;
        t = {1'b0, x} + {1'b0, y} + {32'd0, c};
        return {((x[31] == y[31]) && (t[31] != x[31])), t[32], t[31:0]};
    endfunction

    task automatic test_streaming;
        localparam int N = 1000;
        logic [33:0] q[$];
        logic [33:0] e;
        int cyc = 0, sent = 0, got = 0, first = -1;
        rdy32_out = 1'b1;
        while (got < N && cyc < N + 50) begin
            if (sent < N) begin
                v32_in = 1'b1;
                case (sent)
                    0:       begin a32 = 32'hFFFF_FFFF; b32 = 32'h0;          cin32 = 1'b1; end
                    1:       begin a32 = 32'h7FFF_FFFF; b32 = 32'h1;          cin32 = 1'b0; end
                    2:       begin a32 = 32'h8000_0000; b32 = 32'h8000_0000;  cin32 = 1'b0; end
                    default: begin a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom_range(0, 1)); end
                endcase
            end else begin
                v32_in = 1'b0;
            end
            #1;
            if (vout32 && rdy32_out) begin
                if (first < 0) first = cyc;
                e = (q.size() > 0) ? q.pop_front() : 34'h0;
                n_total++;
                if ({ovf32, cout32, sum32} !== e)
                    $display("FAIL stream_result #%0d got %h want %h", got, {ovf32, cout32, sum32}, e);
                else n_pass++;
                got++;
            end
            if (v32_in && rdy32_in) begin
                q.push_back(model32(a32, b32, cin32));
                sent++;
            end
            tick;
            cyc++;
        end
        v32_in = 1'b0;
        n_total++; if (first !== 6) $display("FAIL stream_first_latency got %0d want 6", first); else n_pass++;
        n_total++; if (got !== N) $display("FAIL stream_count got %0d want %0d", got, N); else n_pass++;
        n_total++; if (cyc !== N + 6) $display("FAIL stream_throughput cycles got %0d want %0d", cyc, N + 6); else n_pass++;
    endtask

    task automatic test_back_pressure;
        localparam int N = 300;
        logic [33:0] q[$];
        logic [33:0] e, prev_out;
        logic [31:0] na, nb;
        logic        nc, prev_stall;
        int cyc = 0, sent = 0, got = 0, bad_rdy = 0, bad_hold = 0;
        na = $urandom; nb = $urandom; nc = 1'($urandom_range(0, 1));
        prev_stall = 1'b0; prev_out = '0;
        while (got < N && cyc < 4 * N + 100) begin
            v32_in = (sent < N); a32 = na; b32 = nb; cin32 = nc;
            rdy32_out = 1'($urandom_range(0, 1));
            #1;
            if (rdy32_in !== !(vout32 && !rdy32_out)) bad_rdy++;
            if (prev_stall && (vout32 !== 1'b1 || {ovf32, cout32, sum32} !== prev_out)) bad_hold++;
            if (vout32 && rdy32_out) begin
                e = (q.size() > 0) ? q.pop_front() : 34'h0;
                n_total++;
                if ({ovf32, cout32, sum32} !== e)
                    $display("FAIL bp_result #%0d got %h want %h", got, {ovf32, cout32, sum32}, e);
                else n_pass++;
                got++;
            end
            if (v32_in && rdy32_in) begin
                q.push_back(model32(a32, b32, cin32));
                sent++;
                na = $urandom; nb = $urandom; nc = 1'($urandom_range(0, 1));
            end
            prev_stall = vout32 && !rdy32_out;
            prev_out   = {ovf32, cout32, sum32};
            tick;
            cyc++;
        end
        v32_in = 1'b0; rdy32_out = 1'b1;
        n_total++; if (got !== N) $display("FAIL bp_count got %0d want %0d", got, N); else n_pass++;
        n_total++; if (bad_rdy !== 0) $display("FAIL bp_in_ready bad cycles got %0d want 0", bad_rdy); else n_pass++;
        n_total++; if (bad_hold !== 0) $display("FAIL bp_hold bad cycles got %0d want 0", bad_hold); else n_pass++;
        n_total++; if (q.size() !== 0) $display("FAIL bp_leftover got %0d want 0", q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int lat;
        rdy32_out = 1'b1;
        for (int i = 0; i < 3; i++) begin
            v32_in = 1'b1; a32 = 32'h100 * (i + 1); b32 = 32'h5; cin32 = 1'b0;
            tick;
        end
        rst = 1'b1; a32 = 32'hDEAD_0000; b32 = 32'h1;
        tick;
        n_total++; if (vout32 !== 1'b0) $display("FAIL midrst_vout got %b want 0", vout32); else n_pass++;
        rst = 1'b0; v32_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_total++;
            if (vout32 !== 1'b0 || rdy32_in !== 1'b1)
                $display("FAIL midrst_stale cycle %0d got vout=%b rdy=%b want 0/1", i, vout32, rdy32_in);
            else n_pass++;
            tick;
        end
        v32_in = 1'b1; a32 = 32'h1111_1111; b32 = 32'h2222_2222; cin32 = 1'b1;
        tick;
        v32_in = 1'b0;
        lat = 1;
        while (vout32 !== 1'b1 && lat < 20) begin
            tick;
            lat++;
        end
        n_total++; if (lat !== 6) $display("FAIL midrst_latency got %0d want 6", lat); else n_pass++;
        n_total++; if ({ovf32, cout32, sum32} !== {2'b00, 32'h3333_3334})
            $display("FAIL midrst_result got %h want %h", {ovf32, cout32, sum32}, {2'b00, 32'h3333_3334});
        else n_pass++;
        tick;
    endtask

    initial begin
        test_reset;
        test_directed16;
`ifdef SKLANSKY_PIPE_SUB_EN
        test_sub;
`endif
        test_streaming;
        test_back_pressure;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout got running want finished");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/sklansky_pipe_adder.md
# sklansky_pipe_adder

Pipelined, parametrised Sklansky parallel-prefix adder with valid/ready flow control. It computes `a + b + cin` over a configurable width, inserting pipeline registers after a configurable number of prefix levels. Back-pressure stalls the whole pipeline, and nothing is dropped or duplicated. It sits in the datapath library next to the combinational prefix-adder family and is used wherever a wide add must close timing at the system clock.

## Interface
- `WIDTH`, 32: operand width in bits. Must be ≥ 2; need not be a power of two.
- `PIPE_EVERY`, 2: prefix levels between pipeline registers. Range is 1 .. `LEVELS`, where `LEVELS = $clog2(WIDTH)`.
- `clk`  in  1: clock. All logic is on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `in_valid`  in  1: operand beat valid.
- `in_ready`  out  1: block can accept a beat this cycle.
- `a`, `b`  in  WIDTH: operands, unsigned or two's complement.
- `cin`  in  1: carry-in.
- `out_valid`  out  1: result beat valid.
- `out_ready`  in  1: downstream accepts the result.
- `sum`  out  WIDTH: `(a + b + cin) mod 2^WIDTH`.
- `cout`  out  1: carry out of bit WIDTH-1.
- `ovf`  out  1: signed overflow, meaning `carry[WIDTH-1] XOR carry[WIDTH]`.
- `sub`  in  1: present only with `SKLANSKY_PIPE_SUB_EN` (see Configuration).

## Operation
- **Stage P (input register).** On a beat transfer (`in_valid && in_ready`), the block registers the bitwise `g = a&b` and `p = a^b`, the carry-in as the position -1 generate term, and the raw `p` for the sum.
- **Prefix tree.** Standard Sklansky structure. At level i, every bit k in an upper half-block of size 2^i combines with the last bit of the lower half-block.
  - Cells whose lower operand is already a final group-generate are gray cells (G only).
  - All other cells are black cells (G and P).
  - Bits not touched at a level pass through unchanged.
- **Pipeline registers.** A register bank sits after levels `PIPE_EVERY`, `2*PIPE_EVERY`, … It always sits after the final level, and holds the G/P vectors plus the propagated `p` and valid bit.
  - Number of tree register banks: `STAGES = ceil(LEVELS/PIPE_EVERY)`.
- **Output stage.** `sum[k] = p[k] ^ Gi[k-1]`, with `Gi[-1] = cin`. `cout = Gi[WIDTH-1]`.
  - The last tree register bank is the output register, so `sum`, `cout` and `ovf` come straight from flops.
- **Flow control.** A global enable, `en = !out_valid || out_ready`.
  - When `en` is 1, every stage register and its valid bit advance. When `en` is 0, all stages hold.
  - `in_ready = en`.
  - Empty stages (valid = 0) do not collapse bubbles. The throughput target is 1 beat/cycle with no stall.
- **Valid tracking.** One valid bit per stage. `out_valid` is the last stage's valid bit.
- **Data hold.** `sum`, `cout` and `ovf` stay stable while `out_valid && !out_ready`.

## Timing
- **Latency.** `LAT = STAGES + 1` cycles from the accepting edge to the edge where `out_valid` rises, assuming no stalls.
  - WIDTH=32, PIPE_EVERY=2: LEVELS=5, STAGES=3, LAT=4.
  - WIDTH=16, PIPE_EVERY=4: LAT=2.
- **Stalls.** Each cycle with `en = 0` adds exactly one cycle of latency to every in-flight beat.
- **Throughput.** One result per cycle when `out_ready` is held high.
- **Reset.** While `rst` is 1, at the clock edge:
  - All stage valids go to 0, so `out_valid` = 0.
  - `sum` = 0, `cout` = 0, `ovf` = 0.
  - `in_ready` = 1 in the first cycle after reset.
- **Reset mid-operation.** All in-flight beats are discarded. A beat presented in the same cycle as `rst` is not accepted.
- **Simultaneous accept and drain.** In-flight beats are not lost.
- **Combinational path.** `in_ready` depends combinationally on `out_ready` (single-level AND/OR). Integrators must not feed it back into `out_ready`.

## Configuration
- Macro: `SKLANSKY_PIPE_SUB_EN`.
- **Defined.** Port `sub` exists. At stage P, when `sub` = 1, `b` is replaced by `~b` and the effective carry-in is `cin | sub`, so the result is `a - b`. `cout` is then the not-borrow.
  - `sub` is sampled with the operands and carried no further.
- **Undefined.** There is no `sub` port, and the block adds only. Datapath and latency are otherwise identical.

## Test plan
- **Full carry ripple.** WIDTH=16, PIPE_EVERY=2: a=0xFFFF, b=0x0001, cin=0, `out_ready` high → after exactly 3 cycles, sum=0x0000, cout=1, ovf=0.
- **Signed overflow.** a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1. With cin=1 and a=b=0xFFFF → sum=0xFFFF, cout=1.
- **Streaming.** 1000 random back-to-back beats at WIDTH=32, PIPE_EVERY=1 → results match the reference model in order, one per cycle, with first `out_valid` at LAT=6.
- **Back-pressure.** Random `out_ready` (50%) with continuous `in_valid` → no drop or duplicate, outputs stable while stalled, and `in_ready` low exactly when `out_valid && !out_ready`.
- **Reset mid-operation.** Assert `rst` for 1 cycle with 3 beats in flight → `out_valid` = 0 the next cycle, no stale result ever appears, and the next accepted beat returns with nominal latency.
- **Subtraction (SKLANSKY_PIPE_SUB_EN).** a=5, b=7, sub=1, WIDTH=8 → sum=0xFE, cout=0. a=7, b=5 → sum=0x02, cout=1.
